lcd_window_scheduler: RTL and testbench

//  Owns the centre position (H_CEN/V_CEN) of the on-screen capture/overlay window used by the LCD counter.
//  Two requesters compete for it: A is the auto-tracker, giving an absolute target; B is the manual pad, giving step moves.

---
 rtl/lcd_window_scheduler.sv | 161 ++++++++++++++++
 tb/tb_lcd_window_scheduler.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_window_scheduler.sv
// Arbitrates tracker (A) and manual pad (B) moves of the capture window centre.
// Grant one cycle after request; commit on the first frame edge after the grant.
module lcd_window_scheduler #(
  parameter logic [11:0] H_OFF  = 12'd200,
  parameter logic [11:0] V_OFF  = 12'd200,
  parameter logic [11:0] H_MAX  = 12'd800,
  parameter logic [11:0] V_MAX  = 12'd480,
  parameter logic [11:0] H_INIT = 12'd450,
  parameter logic [11:0] V_INIT = 12'd250,
  parameter logic [11:0] STEP   = 12'd4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        VS,
  input  logic        REQ_A,
  input  logic [11:0] A_H,
  input  logic [11:0] A_V,
  output logic        GNT_A,
  input  logic        REQ_B,
  input  logic [3:0]  B_DIR,
  output logic        GNT_B,
  output logic [11:0] H_CEN,
  output logic [11:0] V_CEN,
  output logic        UPD,
  output logic        PEND
);

  localparam logic signed [12:0] H_LO   = $signed({1'b0, H_OFF >> 1});
  localparam logic signed [12:0] H_HI   = $signed({1'b0, H_MAX - (H_OFF >> 1)});
  localparam logic signed [12:0] V_LO   = $signed({1'b0, V_OFF >> 1});
  localparam logic signed [12:0] V_HI   = $signed({1'b0, V_MAX - (V_OFF >> 1)});
  localparam logic signed [12:0] STEP_S = $signed({1'b0, STEP});

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      state_q, state_d;
  logic        rr_q, rr_d;
  logic        rvs_q;
  logic        gnt_a_q, gnt_a_d;
  logic        gnt_b_q, gnt_b_d;
  logic        upd_q, upd_d;
  logic        pend_q, pend_d;
  logic [11:0] h_cen_q, h_cen_d;
  logic [11:0] v_cen_q, v_cen_d;
  logic [11:0] tgt_h_q, tgt_h_d;
  logic [11:0] tgt_v_q, tgt_v_d;

  logic              vs_rise;
  logic              any_req;
  logic              pick_a;
  logic              commit;
  logic signed [12:0] b_h, b_v;
  logic [11:0]       a_h_cl, a_v_cl, b_h_cl, b_v_cl;

  function automatic logic [11:0] clamp(input logic signed [12:0] v,
                                        input logic signed [12:0] lo,
                                        input logic signed [12:0] hi);
    logic signed [12:0] r;
    if (v < lo)      r = lo;
    else if (v > hi) r = hi;
    else             r = v;
    return r[11:0];
  endfunction

  assign vs_rise = VS & ~rvs_q;
  assign any_req = REQ_A | REQ_B;
  // rr_q set means A was granted last, so B wins a tie.
  assign pick_a  = REQ_A & (~REQ_B | ~rr_q);
  // A frame edge landing on the grant cycle belongs to the frame the move was granted in.
  assign commit  = (state_q == S_WAIT) & vs_rise & ~gnt_a_q & ~gnt_b_q;

  // B steps are taken from the committed centre; opposing directions cancel.
  always_comb begin
    b_h = $signed({1'b0, h_cen_q});
    b_v = $signed({1'b0, v_cen_q});
    if (B_DIR[1] & ~B_DIR[0]) b_h = b_h - STEP_S;
    if (B_DIR[0] & ~B_DIR[1]) b_h = b_h + STEP_S;
    if (B_DIR[3] & ~B_DIR[2]) b_v = b_v - STEP_S;
    if (B_DIR[2] & ~B_DIR[3]) b_v = b_v + STEP_S;
  end

  assign a_h_cl = clamp($signed({1'b0, A_H}), H_LO, H_HI);
  assign a_v_cl = clamp($signed({1'b0, A_V}), V_LO, V_HI);
  assign b_h_cl = clamp(b_h, H_LO, H_HI);
  assign b_v_cl = clamp(b_v, V_LO, V_HI);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      rr_q    <= 1'b0;
      rvs_q   <= 1'b0;
      gnt_a_q <= 1'b0;
      gnt_b_q <= 1'b0;
      upd_q   <= 1'b0;
      pend_q  <= 1'b0;
      h_cen_q <= H_INIT;
      v_cen_q <= V_INIT;
      tgt_h_q <= H_INIT;
      tgt_v_q <= V_INIT;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      rvs_q   <= VS;
      gnt_a_q <= gnt_a_d;
      gnt_b_q <= gnt_b_d;
      upd_q   <= upd_d;
      pend_q  <= pend_d;
      h_cen_q <= h_cen_d;
      v_cen_q <= v_cen_d;
      tgt_h_q <= tgt_h_d;
      tgt_v_q <= tgt_v_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (any_req) state_d = S_WAIT;
      S_WAIT:  if (commit)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    gnt_a_d = 1'b0;
    gnt_b_d = 1'b0;
    upd_d   = 1'b0;
    rr_d    = rr_q;
    tgt_h_d = tgt_h_q;
    tgt_v_d = tgt_v_q;
    h_cen_d = h_cen_q;
    v_cen_d = v_cen_q;
    if (state_q == S_IDLE && any_req) begin
      if (pick_a) begin
        gnt_a_d = 1'b1;
        rr_d    = 1'b1;
        tgt_h_d = a_h_cl;
        tgt_v_d = a_v_cl;
      end else begin
        gnt_b_d = 1'b1;
        rr_d    = 1'b0;
        tgt_h_d = b_h_cl;
        tgt_v_d = b_v_cl;
      end
    end
    if (commit) begin
      upd_d   = 1'b1;
      h_cen_d = tgt_h_q;
      v_cen_d = tgt_v_q;
    end
    pend_d = (state_d == S_WAIT);
  end

  assign GNT_A = gnt_a_q;
  assign GNT_B = gnt_b_q;
  assign UPD   = upd_q;
  assign PEND  = pend_q;
  assign H_CEN = h_cen_q;
  assign V_CEN = v_cen_q;

endmodule

// File: tb/tb_lcd_window_scheduler.sv
// Directed bench for lcd_window_scheduler: grants, round-robin, clamping, frame-edge commit, reset.
module tb_lcd_window_scheduler;

  logic        CLK = 1'b0;
  logic        RESET, VS, REQ_A, REQ_B;
  logic [11:0] A_H, A_V;
  logic [3:0]  B_DIR;
  logic        GNT_A, GNT_B, UPD, PEND;
  logic [11:0] H_CEN, V_CEN;

  int n_checks = 0;
  int n_fail   = 0;

  lcd_window_scheduler dut (
    .CLK(CLK), .RESET(RESET), .VS(VS),
    .REQ_A(REQ_A), .A_H(A_H), .A_V(A_V), .GNT_A(GNT_A),
    .REQ_B(REQ_B), .B_DIR(B_DIR), .GNT_B(GNT_B),
    .H_CEN(H_CEN), .V_CEN(V_CEN), .UPD(UPD), .PEND(PEND)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic commit_frame(input string tag);
    VS = 1'b1;
    tick();
    chk({tag, " upd"}, 32'(UPD), 1);
    chk({tag, " pend_clr"}, 32'(PEND), 0);
    VS = 1'b0;
    tick();
    chk({tag, " upd_end"}, 32'(UPD), 0);
  endtask

  task automatic do_a(input logic [11:0] h, input logic [11:0] v, input string tag);
    A_H = h; A_V = v; REQ_A = 1'b1;
    tick();
    chk({tag, " gnt_a"}, 32'(GNT_A), 1);
    chk({tag, " pend"}, 32'(PEND), 1);
    REQ_A = 1'b0;
    tick();
    chk({tag, " gnt_a_end"}, 32'(GNT_A), 0);
    commit_frame(tag);
  endtask

  task automatic do_b(input logic [3:0] dir, input string tag);
    B_DIR = dir; REQ_B = 1'b1;
    tick();
    chk({tag, " gnt_b"}, 32'(GNT_B), 1);
    REQ_B = 1'b0;
    tick();
    chk({tag, " gnt_b_end"}, 32'(GNT_B), 0);
    commit_frame(tag);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; VS = 1'b0; REQ_A = 1'b0; REQ_B = 1'b0;
    A_H = '0; A_V = '0; B_DIR = '0;

    // reset state
    do_reset();
    chk("rst h_cen", 32'(H_CEN), 450);
    chk("rst v_cen", 32'(V_CEN), 250);
    chk("rst gnt_a", 32'(GNT_A), 0);
    chk("rst gnt_b", 32'(GNT_B), 0);
    chk("rst upd", 32'(UPD), 0);
    chk("rst pend", 32'(PEND), 0);

    // single A move waits for the frame edge
    A_H = 12'd300; A_V = 12'd200; REQ_A = 1'b1;
    tick();
    chk("t1 gnt_a", 32'(GNT_A), 1);
    chk("t1 pend", 32'(PEND), 1);
    chk("t1 h_hold", 32'(H_CEN), 450);
    REQ_A = 1'b0;
    tick();
    chk("t1 gnt_a_end", 32'(GNT_A), 0);
    chk("t1 h_hold2", 32'(H_CEN), 450);
    chk("t1 upd_idle", 32'(UPD), 0);
    VS = 1'b1;
    tick();
    chk("t1 upd", 32'(UPD), 1);
    chk("t1 h_cen", 32'(H_CEN), 300);
    chk("t1 v_cen", 32'(V_CEN), 200);
    chk("t1 pend_clr", 32'(PEND), 0);
    VS = 1'b0;
    tick();
    chk("t1 upd_end", 32'(UPD), 0);

    // round-robin with both requesting continuously
    do_reset();
    REQ_A = 1'b1; REQ_B = 1'b1; B_DIR = 4'b0000; A_H = 12'd300; A_V = 12'd200;
    tick();
    chk("t2 gnt_a1", 32'(GNT_A), 1);
    chk("t2 gnt_b1", 32'(GNT_B), 0);
    tick();
    chk("t2 wait_gnt_a", 32'(GNT_A), 0);
    chk("t2 wait_gnt_b", 32'(GNT_B), 0);
    VS = 1'b1;
    tick();
    chk("t2 upd1", 32'(UPD), 1);
    chk("t2 h1", 32'(H_CEN), 300);
    chk("t2 no_gnt_at_upd", 32'(GNT_B), 0);
    VS = 1'b0;
    tick();
    chk("t2 gnt_b2", 32'(GNT_B), 1);
    chk("t2 gnt_a2", 32'(GNT_A), 0);
    chk("t2 upd_gone", 32'(UPD), 0);
    tick();
    VS = 1'b1;
    tick();
    chk("t2 upd2", 32'(UPD), 1);
    chk("t2 h2", 32'(H_CEN), 300);
    chk("t2 v2", 32'(V_CEN), 200);
    VS = 1'b0;
    tick();
    chk("t2 gnt_a3", 32'(GNT_A), 1);
    chk("t2 gnt_b3", 32'(GNT_B), 0);
    REQ_A = 1'b0; REQ_B = 1'b0;
    tick();
    commit_frame("t2 c3");

    // B steps and clamping
    do_a(12'd104, 12'd250, "t3 a104");
    chk("t3 h104", 32'(H_CEN), 104);
    do_b(4'b0010, "t3 left1");
    chk("t3 h100", 32'(H_CEN), 100);
    do_b(4'b0010, "t3 left2");
    chk("t3 h_clamp_lo", 32'(H_CEN), 100);
    do_a(12'd4000, 12'd4000, "t3 abig");
    chk("t3 h_clamp_hi", 32'(H_CEN), 700);
    chk("t3 v_clamp_hi", 32'(V_CEN), 380);
    do_b(4'b0001, "t3 right");
    chk("t3 h_right_clamp", 32'(H_CEN), 700);
    do_b(4'b0100, "t3 down");
    chk("t3 v_down_clamp", 32'(V_CEN), 380);
    do_a(12'd0, 12'd0, "t3 azero");
    chk("t3 h_zero", 32'(H_CEN), 100);
    chk("t3 v_zero", 32'(V_CEN), 100);
    do_b(4'b1000, "t3 up");
    chk("t3 v_up_clamp", 32'(V_CEN), 100);
    do_a(12'd400, 12'd240, "t3 a400");
    do_b(4'b1001, "t3 upright");
    chk("t3 h_ur", 32'(H_CEN), 404);
    chk("t3 v_ur", 32'(V_CEN), 236);

    // opposing directions and empty direction
    do_b(4'b1100, "t4 updown");
    chk("t4 v_same", 32'(V_CEN), 236);
    chk("t4 h_same", 32'(H_CEN), 404);
    do_b(4'b0011, "t4 leftright");
    chk("t4 h_lr", 32'(H_CEN), 404);
    do_b(4'b0000, "t4 nodir");
    chk("t4 h_nodir", 32'(H_CEN), 404);
    chk("t4 v_nodir", 32'(V_CEN), 236);

    // B request ignored while a move is pending
    A_H = 12'd500; A_V = 12'd240; REQ_A = 1'b1;
    tick();
    chk("t4 gnt_a", 32'(GNT_A), 1);
    REQ_A = 1'b0; REQ_B = 1'b1; B_DIR = 4'b0001;
    tick();
    chk("t4 wait_gnt_b", 32'(GNT_B), 0);
    tick();
    chk("t4 wait_gnt_b2", 32'(GNT_B), 0);
    REQ_B = 1'b0;
    commit_frame("t4 commit");
    chk("t4 h500", 32'(H_CEN), 500);
    tick();
    chk("t4 no_late_gnt_b", 32'(GNT_B), 0);

    // frame edge coinciding with the grant does not commit
    A_H = 12'd320; A_V = 12'd220; REQ_A = 1'b1;
    tick();
    chk("t5 gnt_a", 32'(GNT_A), 1);
    REQ_A = 1'b0; VS = 1'b1;
    tick();
    chk("t5 no_upd", 32'(UPD), 0);
    chk("t5 h_hold", 32'(H_CEN), 500);
    chk("t5 pend", 32'(PEND), 1);
    VS = 1'b0;
    tick();
    chk("t5 pend2", 32'(PEND), 1);
    commit_frame("t5 commit");
    chk("t5 h320", 32'(H_CEN), 320);
    chk("t5 v220", 32'(V_CEN), 220);

    // reset while waiting discards the move
    A_H = 12'd300; A_V = 12'd200; REQ_A = 1'b1;
    tick();
    chk("t6 gnt_a", 32'(GNT_A), 1);
    REQ_A = 1'b0;
    tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("t6 h_init", 32'(H_CEN), 450);
    chk("t6 v_init", 32'(V_CEN), 250);
    chk("t6 pend", 32'(PEND), 0);
    VS = 1'b1;
    tick();
    chk("t6 no_upd", 32'(UPD), 0);
    chk("t6 h_after_vs", 32'(H_CEN), 450);
    VS = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
